// File: rtl/conv_pass_sched_pkg.sv
// Shared definitions for the conv pass scheduler: derived geometry helpers and
// the FSM state encoding.
package conv_pass_sched_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_WLOAD  = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    function automatic int calc_ps(input int fm_size, input int padding);
        return fm_size + 2 * padding;
    endfunction

    function automatic int calc_ngrp(input int fm_size, input int num_pe);
        return (fm_size + num_pe - 1) / num_pe;
    endfunction

    function automatic int calc_out_size(input int fm_size, input int padding,
                                         input int kernel_size);
        return fm_size + 2 * padding - kernel_size + 1;
    endfunction

    // Counter width that never collapses to zero bits for a range of one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_pass_addrgen.sv
// Address generator for the weight ROM and feature-map memory; the weight enable
// is the address issue delayed by the ROM's one-cycle read latency.
module conv_pass_addrgen
    import conv_pass_sched_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_PE      = 4,
    parameter int PS          = 30,
    parameter int WADDR_W     = 10,
    parameter int FADDR_W     = 16,
    parameter int OC_W        = 3,
    parameter int GRP_W       = 3,
    parameter int WIDX_W      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_w_issue,
    input  logic               i_fm_active,
    input  logic [OC_W-1:0]    i_oc,
    input  logic [GRP_W-1:0]   i_grp,
    input  logic [WIDX_W-1:0]  i_widx,
    input  logic [FADDR_W-1:0] i_beat,
    output logic [WADDR_W-1:0] o_weight_addr,
    output logic               o_weight_en,
    output logic [FADDR_W-1:0] o_fm_addr
);

    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;

    always_comb begin
        o_weight_addr = '0;
        o_fm_addr     = '0;
        if (i_w_issue) begin
            o_weight_addr = WADDR_W'(i_oc) * WADDR_W'(KK) + WADDR_W'(i_widx);
        end
        if (i_fm_active) begin
            o_fm_addr = FADDR_W'(i_grp) * FADDR_W'(NUM_PE * PS) + i_beat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_weight_en <= 1'b0;
        end else begin
            o_weight_en <= i_w_issue;
        end
    end

endmodule

// File: rtl/conv_pass_sched.sv
// Layer pass scheduler: runs one conv_blk through every (output channel, row
// group) pass -- block reset, weight load, padded FM stream, result drain.
module conv_pass_sched
    import conv_pass_sched_pkg::*;
#(
    parameter int KERNEL_SIZE  = 3,
    parameter int FM_SIZE      = 28,
    parameter int PADDING      = 1,
    parameter int NUM_PE       = 4,
    parameter int OUT_FM_CH    = 6,
    parameter int RES_PER_PASS = 28,
    parameter int WADDR_W      = 10,
    parameter int FADDR_W      = 16
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst,
    input  logic                                            i_start,
    input  logic                                            i_fm_valid,
    input  logic                                            i_res_en,
    output logic                                            o_blk_rst,
    output logic [WADDR_W-1:0]                              o_weight_addr,
    output logic                                            o_weight_en,
    output logic                                            o_go,
    output logic [FADDR_W-1:0]                              o_fm_addr,
    output logic [width_of(OUT_FM_CH)-1:0]                  o_oc,
    output logic [width_of(calc_ngrp(FM_SIZE, NUM_PE))-1:0] o_grp,
    output logic                                            o_busy,
    output logic                                            o_done
);

    localparam int PS     = calc_ps(FM_SIZE, PADDING);
    localparam int NGRP   = calc_ngrp(FM_SIZE, NUM_PE);
    localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int OC_W   = width_of(OUT_FM_CH);
    localparam int GRP_W  = width_of(NGRP);
    localparam int WIDX_W = width_of(KK + 1);
    localparam int RES_W  = width_of(RES_PER_PASS + 1);

    logic [2:0]         state;
    logic [OC_W-1:0]    oc;
    logic [GRP_W-1:0]   grp;
    logic [WIDX_W-1:0]  widx;
    logic [FADDR_W-1:0] beat;
    logic [RES_W-1:0]   res_cnt;
    logic [RES_W-1:0]   res_cnt_nxt;
    logic               w_issue;
    logic               fm_active;
    logic               last_beat;
    logic               res_full;
    logic               last_pass;

    // widx runs one past the last weight so WLOAD also covers the final enable beat.
    always_comb begin
        w_issue     = (state == ST_WLOAD) && (widx < WIDX_W'(KK));
        fm_active   = (state == ST_STREAM);
        o_go        = fm_active && i_fm_valid;
        last_beat   = o_go && (beat == FADDR_W'(PS * PS - 1));
        res_cnt_nxt = res_cnt;
        if ((state == ST_STREAM || state == ST_DRAIN) && i_res_en &&
            (res_cnt != RES_W'(RES_PER_PASS))) begin
            res_cnt_nxt = res_cnt + RES_W'(1);
        end
        res_full  = (res_cnt_nxt == RES_W'(RES_PER_PASS));
        last_pass = (grp == GRP_W'(NGRP - 1)) && (oc == OC_W'(OUT_FM_CH - 1));
        o_blk_rst = (state == ST_CLR);
        o_done    = (state == ST_DONE);
        o_busy    = (state != ST_IDLE) && (state != ST_DONE);
        o_oc      = oc;
        o_grp     = grp;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            oc      <= '0;
            grp     <= '0;
            widx    <= '0;
            beat    <= '0;
            res_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        oc    <= '0;
                        grp   <= '0;
                        state <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    widx  <= '0;
                    state <= ST_WLOAD;
                end
                ST_WLOAD: begin
                    if (widx == WIDX_W'(KK)) begin
                        beat    <= '0;
                        res_cnt <= '0;
                        state   <= ST_STREAM;
                    end else begin
                        widx <= widx + WIDX_W'(1);
                    end
                end
                ST_STREAM: begin
                    res_cnt <= res_cnt_nxt;
                    if (o_go) begin
                        beat <= beat + FADDR_W'(1);
                    end
                    if (last_beat) begin
                        state <= res_full ? ST_NEXT : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    res_cnt <= res_cnt_nxt;
                    if (res_full) begin
                        state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (last_pass) begin
                        oc    <= '0;
                        grp   <= '0;
                        state <= ST_DONE;
                    end else begin
                        if (grp != GRP_W'(NGRP - 1)) begin
                            grp <= grp + GRP_W'(1);
                        end else begin
                            grp <= '0;
                            oc  <= oc + OC_W'(1);
                        end
                        state <= ST_CLR;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    conv_pass_addrgen #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .NUM_PE      (NUM_PE),
        .PS          (PS),
        .WADDR_W     (WADDR_W),
        .FADDR_W     (FADDR_W),
        .OC_W        (OC_W),
        .GRP_W       (GRP_W),
        .WIDX_W      (WIDX_W)
    ) u_addrgen (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_w_issue     (w_issue),
        .i_fm_active   (fm_active),
        .i_oc          (oc),
        .i_grp         (grp),
        .i_widx        (widx),
        .i_beat        (beat),
        .o_weight_addr (o_weight_addr),
        .o_weight_en   (o_weight_en),
        .o_fm_addr     (o_fm_addr)
    );

endmodule

// File: tb/tb_conv_pass_sched.sv
// Self-checking bench for conv_pass_sched: a pass-timeline reference model checks
// every cycle, plus per-pass tables and targeted stall/early/abort sequences.
module tb_conv_pass_sched;

    localparam int KERNEL_SIZE  = 3;
    localparam int FM_SIZE      = 4;
    localparam int PADDING      = 1;
    localparam int NUM_PE       = 2;
    localparam int OUT_FM_CH    = 2;
    localparam int RES_PER_PASS = 4;
    localparam int WADDR_W      = 10;
    localparam int FADDR_W      = 16;

    localparam int PS         = FM_SIZE + 2 * PADDING;
    localparam int NGRP       = (FM_SIZE + NUM_PE - 1) / NUM_PE;
    localparam int KK         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NPASS      = OUT_FM_CH * NGRP;
    localparam int BEATS      = PS * PS;
    localparam int GRP_STRIDE = NUM_PE * PS;
    localparam int STREAM_OFF = KK + 2;

    localparam int M_BASIC  = 0;
    localparam int M_STALL  = 1;
    localparam int M_EARLY  = 2;
    localparam int M_ABORT  = 3;
    localparam int M_RANDOM = 4;

    typedef struct {
        int oc;
        int grp;
        int wen;
        int go;
        int wfirst;
        int wlast;
        int fbase;
    } pass_vec_t;

    logic clk = 1'b0;
    logic rst, start, fm_valid, res_en;
    logic               blk_rst, weight_en, go, busy, done;
    logic [WADDR_W-1:0] weight_addr;
    logic [FADDR_W-1:0] fm_addr;
    logic [0:0]         oc_out, grp_out;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  check_en = 0;
    int  cyc = 0;

    // Reference model: pass timeline measured in cycles from each block reset.
    bit  active, in_pass, closed, pending, next_done, done_now;
    int  t_pass, pidx, beats, res_seen, next_t;
    bit  m_blk, m_wen, m_go, m_busy, m_done;
    int  m_waddr, m_faddr, m_oc, m_grp;

    // Observed per-pass activity.
    pass_vec_t tbl [NPASS];
    int obs_pass, obs_done, obs_last_go, prev_waddr;
    int obs_oc [NPASS], obs_grp [NPASS], obs_wen [NPASS], obs_go [NPASS];
    int obs_wfirst [NPASS], obs_wlast [NPASS], obs_fbase [NPASS], obs_gap [NPASS];

    always #5 clk = ~clk;

    conv_pass_sched #(
        .KERNEL_SIZE  (KERNEL_SIZE),
        .FM_SIZE      (FM_SIZE),
        .PADDING      (PADDING),
        .NUM_PE       (NUM_PE),
        .OUT_FM_CH    (OUT_FM_CH),
        .RES_PER_PASS (RES_PER_PASS),
        .WADDR_W      (WADDR_W),
        .FADDR_W      (FADDR_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_fm_valid    (fm_valid),
        .i_res_en      (res_en),
        .o_blk_rst     (blk_rst),
        .o_weight_addr (weight_addr),
        .o_weight_en   (weight_en),
        .o_go          (go),
        .o_fm_addr     (fm_addr),
        .o_oc          (oc_out),
        .o_grp         (grp_out),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_begin();
        done_now = 0;
        if (pending && cyc == next_t) begin
            pending = 0;
            if (next_done) begin
                done_now = 1;
                in_pass  = 0;
            end else begin
                pidx++;
                t_pass   = cyc;
                beats    = 0;
                res_seen = 0;
                closed   = 0;
                in_pass  = 1;
            end
        end
    endtask

    task automatic model_expect();
        int off;
        bit issue, strm;
        off     = cyc - t_pass;
        issue   = in_pass && off >= 1 && off <= KK;
        strm    = in_pass && off >= STREAM_OFF && beats < BEATS;
        m_blk   = in_pass && off == 0;
        m_wen   = in_pass && off >= 2 && off <= KK + 1;
        m_waddr = issue ? (pidx / NGRP) * KK + off - 1 : 0;
        m_go    = strm && fm_valid;
        m_faddr = strm ? (pidx % NGRP) * GRP_STRIDE + beats : 0;
        m_oc    = in_pass ? pidx / NGRP : 0;
        m_grp   = in_pass ? pidx % NGRP : 0;
        m_busy  = active && !done_now;
        m_done  = done_now;
    endtask

    task automatic model_end();
        if (rst) begin
            active = 0; in_pass = 0; pending = 0; closed = 0; pidx = -1;
            return;
        end
        if (done_now) begin
            active = 0;
        end else if (!active && start) begin
            active = 1; pending = 1; next_t = cyc + 1; next_done = 0; pidx = -1;
        end
        if (in_pass && !closed) begin
            if (m_go) beats++;
            if ((cyc - t_pass) >= STREAM_OFF && res_en && res_seen < RES_PER_PASS) res_seen++;
            if (beats == BEATS && res_seen == RES_PER_PASS) begin
                closed = 1; pending = 1; next_t = cyc + 2; next_done = (pidx == NPASS - 1);
            end
        end
    endtask

    task automatic checkOutput();
        if (!check_en) return;
        check($sformatf("cycle %0d outputs", cyc),
              {blk_rst, weight_en, weight_addr, go, fm_addr, oc_out, grp_out, busy, done},
              {m_blk, m_wen, WADDR_W'(m_waddr), m_go, FADDR_W'(m_faddr),
               1'(m_oc), 1'(m_grp), m_busy, m_done});
        if (blk_rst) begin
            if (obs_pass >= 0 && obs_pass < NPASS) obs_gap[obs_pass] = cyc - obs_last_go;
            obs_pass++;
            if (obs_pass < NPASS) begin
                obs_oc[obs_pass] = int'(oc_out); obs_grp[obs_pass] = int'(grp_out);
                obs_wen[obs_pass] = 0; obs_go[obs_pass] = 0;
                obs_wfirst[obs_pass] = -1; obs_fbase[obs_pass] = -1;
            end
        end
        if (obs_pass >= 0 && obs_pass < NPASS) begin
            if (weight_en) begin
                obs_wen[obs_pass]++;
                if (obs_wfirst[obs_pass] < 0) obs_wfirst[obs_pass] = prev_waddr;
                obs_wlast[obs_pass] = prev_waddr;
            end
            if (go) begin
                obs_go[obs_pass]++;
                if (obs_fbase[obs_pass] < 0) obs_fbase[obs_pass] = int'(fm_addr);
                obs_last_go = cyc;
            end
        end
        if (done) begin
            obs_done++;
            if (obs_pass >= 0 && obs_pass < NPASS) obs_gap[obs_pass] = cyc - obs_last_go;
        end
        prev_waddr = int'(weight_addr);
    endtask

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
        model_begin();
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic r, input logic rs);
        start = s; fm_valid = v; res_en = r; rst = rs;
        #1;
        model_expect();
        checkOutput();
        model_end();
    endtask

    task automatic clear_obs();
        obs_pass = -1; obs_done = 0; obs_last_go = 0; prev_waddr = 0;
        for (int p = 0; p < NPASS; p++) begin
            obs_oc[p] = -1; obs_grp[p] = -1; obs_wen[p] = 0; obs_go[p] = 0;
            obs_wfirst[p] = -1; obs_wlast[p] = -1; obs_fbase[p] = -1; obs_gap[p] = -1;
        end
    endtask

    task automatic run_layer(input int mode);
        int budget, stall_left, seen_pidx;
        logic s, v, r, rs;
        bit strm, drain_win, chk_ignore;
        clear_obs();
        budget = 0; stall_left = 0; seen_pidx = -1; chk_ignore = 0;
        next_cycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        while (active && budget < 3000) begin
            budget++;
            next_cycle();
            s = 0; v = 1; r = 0; rs = 0;
            if (in_pass && pidx != seen_pidx) begin
                seen_pidx = pidx; stall_left = 5;
            end
            strm      = in_pass && (cyc - t_pass) >= STREAM_OFF && beats < BEATS;
            drain_win = in_pass && (cyc - t_pass) >= STREAM_OFF && !closed;
            case (mode)
                M_STALL: begin
                    if (strm && beats == 10 && stall_left > 0) begin
                        v = 0; stall_left--;
                    end
                    r = drain_win && beats == BEATS;
                end
                M_EARLY: r = strm && (beats % 4 == 3) && beats <= 19;
                M_ABORT: begin
                    r  = drain_win && beats == BEATS;
                    s  = (pidx == 0) && strm && beats == 5;
                    rs = (pidx == 1) && strm && beats == 20;
                end
                M_RANDOM: begin
                    v = ($urandom_range(0, 3) != 0);
                    r = ($urandom_range(0, 5) == 0);
                    s = ($urandom_range(0, 40) == 0);
                end
                default: r = drain_win && beats == BEATS;
            endcase
            applyStimulus(s, v, r, rs);
            if (chk_ignore) begin
                check("start while busy: busy", 64'(busy), 64'(1));
                check("start while busy: blk_rst", 64'(blk_rst), 64'(0));
                chk_ignore = 0;
            end
            if (mode == M_ABORT && s) chk_ignore = 1;
            if (mode == M_STALL && !v) begin
                check("stall go", 64'(go), 64'(0));
                check("stall fm_addr", 64'(fm_addr), (seen_pidx % NGRP == 0) ? 64'(10) : 64'(22));
            end
        end
        if (active) check("layer cycle budget", 64'(0), 64'(1));
    endtask

    task automatic check_table();
        for (int p = 0; p < NPASS; p++) begin
            check($sformatf("pass%0d oc", p),     64'(obs_oc[p]),     64'(tbl[p].oc));
            check($sformatf("pass%0d grp", p),    64'(obs_grp[p]),    64'(tbl[p].grp));
            check($sformatf("pass%0d wen", p),    64'(obs_wen[p]),    64'(tbl[p].wen));
            check($sformatf("pass%0d go", p),     64'(obs_go[p]),     64'(tbl[p].go));
            check($sformatf("pass%0d wfirst", p), 64'(obs_wfirst[p]), 64'(tbl[p].wfirst));
            check($sformatf("pass%0d wlast", p),  64'(obs_wlast[p]),  64'(tbl[p].wlast));
            check($sformatf("pass%0d fbase", p),  64'(obs_fbase[p]),  64'(tbl[p].fbase));
        end
        check("pass count", 64'(obs_pass + 1), 64'(NPASS));
        check("done pulses", 64'(obs_done), 64'(1));
    endtask

    initial begin
        tbl[0] = '{0, 0, 9, 36, 0, 8, 0};
        tbl[1] = '{0, 1, 9, 36, 0, 8, 12};
        tbl[2] = '{1, 0, 9, 36, 9, 17, 0};
        tbl[3] = '{1, 1, 9, 36, 9, 17, 12};
        active = 0; in_pass = 0; pending = 0; closed = 0; pidx = -1; t_pass = 0;
        beats = 0; res_seen = 0; next_t = 0; next_done = 0; done_now = 0;
        rst = 1; start = 0; fm_valid = 0; res_en = 0;
        clear_obs();

        repeat (2) begin
            next_cycle();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check_en = 1;
        next_cycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        check("reset outputs", {blk_rst, weight_en, weight_addr, go, fm_addr, oc_out, grp_out, busy, done}, 64'(0));

        run_layer(M_BASIC);
        check_table();

        run_layer(M_STALL);
        check_table();

        run_layer(M_EARLY);
        check_table();
        for (int p = 0; p < NPASS; p++)
            check($sformatf("early pass%0d last go to next", p), 64'(obs_gap[p]), 64'(2));

        run_layer(M_ABORT);
        next_cycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort outputs", {blk_rst, weight_en, weight_addr, go, fm_addr, oc_out, grp_out, busy, done}, 64'(0));
        repeat (3) begin
            next_cycle();
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            check("abort no done", 64'(done), 64'(0));
        end
        run_layer(M_BASIC);
        check_table();

        repeat (3) begin
            run_layer(M_RANDOM);
            check("random pass count", 64'(obs_pass + 1), 64'(NPASS));
            check("random done pulses", 64'(obs_done), 64'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
